// File: rtl/jump_sequencer_if.sv
// Player controls in, game/physics status out; the game block drives the slave side.
interface jump_sequencer_if;
  logic        button_jump;
  logic        collision;
  logic [5:0]  dinosaur_height;
  logic        game_status;
  logic        game_over;
  logic [15:0] score;
  logic        tick;

  modport master (
    output button_jump, collision,
    input  dinosaur_height, game_status, game_over, score, tick
  );

  modport slave (
    input  button_jump, collision,
    output dinosaur_height, game_status, game_over, score, tick
  );
endinterface

// File: rtl/jump_sequencer.sv
// Dinosaur jump/score game FSM on a divided physics tick; all outputs registered, one cycle after the cause.
// No backpressure (level inputs only); define JUMP_HOLD_EN to compile in the apex-hold state.
module jump_sequencer #(
  parameter int TICK_DIV   = 250000,
  parameter int JUMP_PEAK  = 40,
  parameter int HOLD_TICKS = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  jump_sequencer_if.slave  bus
);

  localparam int              CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [5:0]      PEAK     = 6'(JUMP_PEAK);

  if (TICK_DIV < 2 || TICK_DIV > (1 << 20) || JUMP_PEAK < 1 || JUMP_PEAK > 63 ||
      HOLD_TICKS < 1 || HOLD_TICKS > 255) begin : g_bad_params
    $error("jump_sequencer: parameter out of legal range");
  end

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    RISE,
`ifdef JUMP_HOLD_EN
    HOLD,
`endif
    FALL,
    OVER
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic             btn_prev;
  logic [5:0]       height_q;
  logic             status_q;
  logic             over_q;
  logic [15:0]      score_q;
  logic             tick_q;
`ifdef JUMP_HOLD_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);
  logic [7:0]       hold_cnt;
`endif

  logic        press;
  logic        tick_last;
  logic        playing;
  logic [15:0] score_sat;

  assign press     = bus.button_jump & ~btn_prev;
  assign tick_last = (tick_cnt == CNT_LAST);
  assign playing   = (state != IDLE) && (state != OVER);
  assign score_sat = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      tick_cnt <= '0;
      btn_prev <= 1'b1;  // a button held through reset must not look like a press
      height_q <= '0;
      status_q <= 1'b0;
      over_q   <= 1'b0;
      score_q  <= '0;
      tick_q   <= 1'b0;
`ifdef JUMP_HOLD_EN
      hold_cnt <= '0;
`endif
    end else begin
      btn_prev <= bus.button_jump;
      tick_q   <= tick_last;
      tick_cnt <= tick_last ? '0 : tick_cnt + CNT_W'(1);

      // Collision beats press and tick, so the hit tick is not scored.
      if (playing && bus.collision) begin
        state    <= OVER;
        status_q <= 1'b0;
        over_q   <= 1'b1;
      end else begin
        if (playing && tick_last) score_q <= score_sat;
        case (state)
          IDLE: begin
            if (press) begin
              state    <= RUN;
              status_q <= 1'b1;
              score_q  <= '0;
              tick_cnt <= '0;
            end
          end
          RUN: begin
            if (press) state <= RISE;
          end
          RISE: begin
            if (tick_last && height_q != PEAK) begin
              height_q <= height_q + 6'd1;
              if (height_q + 6'd1 == PEAK) begin
`ifdef JUMP_HOLD_EN
                state    <= HOLD;
                hold_cnt <= '0;
`else
                state    <= FALL;
`endif
              end
            end
          end
`ifdef JUMP_HOLD_EN
          HOLD: begin
            if (!bus.button_jump) begin
              state <= FALL;
            end else if (tick_last) begin
              if (hold_cnt == HOLD_LAST) state <= FALL;
              else                       hold_cnt <= hold_cnt + 8'd1;
            end
          end
`endif
          FALL: begin
            if (tick_last && height_q != 6'd0) begin
              height_q <= height_q - 6'd1;
              if (height_q == 6'd1) state <= RUN;
            end
          end
          OVER: begin
            if (press) begin
              state    <= IDLE;
              height_q <= '0;
              over_q   <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.dinosaur_height = height_q;
  assign bus.game_status     = status_q;
  assign bus.game_over       = over_q;
  assign bus.score           = score_q;
  assign bus.tick            = tick_q;

endmodule

// File: doc/jump_sequencer.md
JUMP_SEQUENCER -- requirements
Module: jump_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 250000: clock cycles per physics tick, legal range 2..2^20.
REQ-002 SHALL have parameter JUMP_PEAK, default 40: apex height in ticks, legal range 1..63.
REQ-003 SHALL have parameter HOLD_TICKS, default 8: maximum apex hold ticks, legal range 1..255; used only with JUMP_HOLD_EN.
REQ-004 SHALL have port CLK  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port RST_N  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port button_jump  in  1  jump/start button level, already synchronous to CLK.
REQ-007 SHALL have port collision  in  1  obstacle-hit level from the obstacle logic.
REQ-008 SHALL have port dinosaur_height  out  6  registered dinosaur height above ground.
REQ-009 SHALL have port game_status  out  1  registered; 1 in RUN/RISE/HOLD/FALL.
REQ-010 SHALL have port game_over  out  1  registered; 1 only in OVER.
REQ-011 SHALL have port score  out  16  registered; play ticks survived, binary.
REQ-012 SHALL have port tick  out  1  registered one-cycle physics-tick pulse.

Function
REQ-013 SHALL define press = button_jump AND NOT btn_prev, where btn_prev is button_jump registered one cycle.
REQ-014 SHALL implement FSM states IDLE, RUN, RISE, HOLD, FALL, OVER; all outputs registered, one-cycle latency from the causing edge.
REQ-015 SHALL run tick counter 0..TICK_DIV-1 in every state and pulse tick in the cycle after it reaches TICK_DIV-1, then wrap to 0.
REQ-016 SHALL, in IDLE on press, clear score, clear tick counter, and enter RUN.
REQ-017 SHALL, in RUN, increment score on each tick, saturating at 65535, with no wrap.
REQ-018 SHALL, in RUN on press, enter RISE; height stays 0 until the next tick.
REQ-019 SHALL, in RISE on each tick, increment height by 1; on reaching JUMP_PEAK, enter HOLD (macro defined) or FALL (macro undefined).
REQ-020 SHALL, in FALL on each tick, decrement height by 1; on reaching 0, enter RUN.
REQ-021 SHALL ignore press in RISE/HOLD/FALL: no double jump.
REQ-022 SHALL keep incrementing score on ticks in RISE/HOLD/FALL.
REQ-023 SHALL, on collision=1 in RUN/RISE/HOLD/FALL, enter OVER; collision overrides press and tick in the same cycle, and score does not increment that cycle.
REQ-024 SHALL freeze height and score in OVER.
REQ-025 SHALL, in OVER on press, enter IDLE with height 0; score holds until the next IDLE->RUN transition.
REQ-026 SHALL ignore collision in IDLE and OVER.
REQ-027 SHALL keep height within 0..JUMP_PEAK: no underflow below 0, no overflow above JUMP_PEAK.

Reset
REQ-028 SHALL, while RST_N=0, asynchronously force: state IDLE, dinosaur_height 0, game_status 0, game_over 0, score 0, tick 0, tick counter 0, hold counter 0, btn_prev 1.
REQ-029 SHALL not count a button held through reset deassertion as a press; btn_prev=1 guarantees this.
REQ-030 SHALL return to IDLE immediately on reset asserted mid-jump or in OVER, with no residual height.

Configuration
REQ-031 SHALL use macro JUMP_HOLD_EN to compile the apex-hold feature in or out.
REQ-032 SHALL, with JUMP_HOLD_EN defined, stay in HOLD at JUMP_PEAK while button_jump=1, counting ticks; enter FALL when button_jump=0 or after HOLD_TICKS ticks, whichever comes first.
REQ-033 SHALL, without JUMP_HOLD_EN, have no HOLD state or hold counter; RISE goes directly to FALL at JUMP_PEAK.

Verification (bench: TICK_DIV=4, JUMP_PEAK=5, HOLD_TICKS=3)
REQ-034 SHALL cover start: button held across reset release, then released -> stays IDLE; next press -> game_status=1, score=0, tick every 4 cycles, score=3 after 3 ticks.
REQ-035 SHALL cover jump without macro: press in RUN -> height 1,2,3,4,5,4,3,2,1,0 on successive ticks, then RUN; second press mid-air has no effect.
REQ-036 SHALL cover hold with JUMP_HOLD_EN: button held -> height stays 5 for exactly 3 ticks, then falls; release after 1 tick -> falls on the next tick.
REQ-037 SHALL cover collision: collision=1 at height 3, same cycle as tick and press -> game_over=1, game_status=0, height 3 and score frozen; press -> IDLE, height 0.
REQ-038 SHALL cover saturation: force score to 65534 in RUN, 3 ticks -> score 65535, no wrap.
REQ-039 SHALL cover async reset: RST_N low mid-FALL between clock edges -> all outputs 0 before the next CLK edge.
